// File: rtl/pc_pkg.sv
// Shared encodings for the program-counter generator.
// Includes the next-PC select codes, the FSM states and a saturating increment.
package pc_pkg;

    typedef enum logic [1:0] {
        SEQ = 2'b00,
        BR  = 2'b01,
        J   = 2'b10,
        JR  = 2'b11
    } pcsrc_t;

    typedef enum logic [1:0] {
        HOLD   = 2'b00,
        RUN    = 2'b01,
        HALTED = 2'b10,
        ERROR  = 2'b11
    } state_t;

    localparam logic [31:0] PC_STEP = 32'd4;

    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/pc_target.sv
// Next-PC target selection and legality check against the instruction memory size.
// Purely combinational; the registers that consume the result live in pc_gen.
module pc_target #(
    parameter int MEM_BYTES = 256
) (
    input  logic [31:0] pc4,
    input  logic [1:0]  pcsrc,
    input  logic        zero,
    input  logic [15:0] imme,
    input  logic [25:0] addr,
    input  logic [31:0] regdata,
    output logic [31:0] target,
    output logic        legal
);
    import pc_pkg::*;

    localparam logic [31:0] LAST_WORD = 32'(MEM_BYTES - 4);

    logic [31:0] br_offset;
    assign br_offset = {{14{imme[15]}}, imme, 2'b00};

    always_comb begin
        target = pc4;
        case (pcsrc_t'(pcsrc))
            SEQ:     target = pc4;
            BR:      target = zero ? (pc4 + br_offset) : pc4;
            J:       target = {pc4[31:28], addr, 2'b00};
            JR:      target = regdata;
            default: target = pc4;
        endcase
    end

    // A fetch must be word aligned and the whole word must fit in memory.
    assign legal = (target[1:0] == 2'b00) && (target <= LAST_WORD);

endmodule

// File: rtl/pc_gen.sv
// Program counter generator: HOLD/RUN/HALTED/ERROR control FSM, PC register
// and saturating retired-instruction counter.
module pc_gen #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          MEM_BYTES = 256
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        Stall,
    input  logic        Halt,
    input  logic [1:0]  PCSrc,
    input  logic        Zero,
    input  logic [15:0] imme,
    input  logic [25:0] addr,
    input  logic [31:0] RegData,
    output logic [31:0] PC,
    output logic [31:0] PC4,
    output logic        Running,
    output logic        Halted,
    output logic        AddrErr,
    output logic [31:0] InstCount
);
    import pc_pkg::*;

    state_t      state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic [31:0] count_reg, count_next;
    logic [31:0] target;
    logic        legal;

    assign PC4 = pc_reg + PC_STEP;

    pc_target #(
        .MEM_BYTES (MEM_BYTES)
    ) u_target (
        .pc4     (PC4),
        .pcsrc   (PCSrc),
        .zero    (Zero),
        .imme    (imme),
        .addr    (addr),
        .regdata (RegData),
        .target  (target),
        .legal   (legal)
    );

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_reg <= HOLD;
            pc_reg    <= RESET_PC;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            count_reg <= count_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        count_next = count_reg;
        case (state_reg)
            // Leaving HOLD does not advance PC so the RESET_PC instruction executes.
            HOLD: state_next = RUN;
            RUN: begin
                if (!Stall) begin
                    count_next = sat_inc(count_reg);
                    if (Halt) begin
                        state_next = HALTED;
                    end else if (legal) begin
                        pc_next = target;
                    end else begin
                        state_next = ERROR;
                    end
                end
            end
            HALTED, ERROR: begin
                state_next = state_reg;
            end
            default: state_next = HOLD;
        endcase
    end

    assign PC        = pc_reg;
    assign InstCount = count_reg;
    assign Running   = (state_reg == RUN);
    assign Halted    = (state_reg == HALTED);
    assign AddrErr   = (state_reg == ERROR);

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios plus randomized stimulus
// compared against a behavioural model of the PC rules.
module tb_pc_gen;

    localparam int          MEM = 256;
    localparam logic [31:0] RPC = 32'h0000_0000;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        Stall;
    logic        Halt;
    logic [1:0]  PCSrc;
    logic        Zero;
    logic [15:0] imme;
    logic [25:0] addr;
    logic [31:0] RegData;
    logic [31:0] PC;
    logic [31:0] PC4;
    logic        Running;
    logic        Halted;
    logic        AddrErr;
    logic [31:0] InstCount;

    int checks = 0;
    int errors = 0;

    // model: 0 = hold, 1 = run, 2 = halted, 3 = error
    int          m_state;
    logic [31:0] m_pc;
    logic [31:0] m_cnt;

    pc_gen #(
        .RESET_PC  (RPC),
        .MEM_BYTES (MEM)
    ) dut (
        .CLK       (CLK),
        .Reset     (Reset),
        .Stall     (Stall),
        .Halt      (Halt),
        .PCSrc     (PCSrc),
        .Zero      (Zero),
        .imme      (imme),
        .addr      (addr),
        .RegData   (RegData),
        .PC        (PC),
        .PC4       (PC4),
        .Running   (Running),
        .Halted    (Halted),
        .AddrErr   (AddrErr),
        .InstCount (InstCount)
    );

    always #5 CLK = ~CLK;

    task automatic model_reset();
        m_state = 0;
        m_pc    = RPC;
        m_cnt   = 32'd0;
    endtask

    function automatic logic [2:0] m_flags();
        return {m_state == 1, m_state == 2, m_state == 3};
    endfunction

    // Advance the model by one rising edge using the inputs currently applied.
    task automatic model_step();
        logic [31:0] seq;
        logic [31:0] t;
        longint      off;
        seq = m_pc + 32'd4;
        if (m_state == 0) begin
            m_state = 1;
        end else if (m_state == 1 && !Stall) begin
            if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
            if (Halt) begin
                m_state = 2;
            end else begin
                case (PCSrc)
                    2'd0: t = seq;
                    2'd1: begin
                        off = longint'($signed(imme)) * 4;
                        t = Zero ? 32'(longint'(seq) + off) : seq;
                    end
                    2'd2: t = {seq[31:28], addr, 2'b00};
                    default: t = RegData;
                endcase
                if ((t % 4 == 0) && (longint'(t) <= longint'(MEM - 4))) m_pc = t;
                else m_state = 3;
            end
        end
    endtask

    task automatic tick(input string tag);
        model_step();
        @(posedge CLK);
        #1;
        $display("%s: PCSrc=%0d Stall=%b Halt=%b -> PC=%h InstCount=%0d RHE=%b%b%b",
                 tag, PCSrc, Stall, Halt, PC, InstCount, Running, Halted, AddrErr);
    endtask

    // Called just after a rising edge; the pulse ends well before the next one.
    task automatic do_reset();
        Reset = 1'b1;
        model_reset();
        #2;
        Reset = 1'b0;
    endtask

    task automatic idle_inputs();
        Stall = 1'b0; Halt = 1'b0; PCSrc = 2'd0; Zero = 1'b0;
        imme = 16'd0; addr = 26'd0; RegData = 32'd0;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        checks++;
        if (PC !== RPC || PC4 !== RPC + 32'd4) begin
            errors++;
            $display("FAIL reset_pc: PC=%h PC4=%h required %h %h", PC, PC4, RPC, RPC + 32'd4);
        end
        checks++;
        if ({Running, Halted, AddrErr} !== 3'b000 || InstCount !== 32'd0) begin
            errors++;
            $display("FAIL reset_state: RHE=%b%b%b InstCount=%0d required 000 0",
                     Running, Halted, AddrErr, InstCount);
        end
        Reset = 1'b0;
        tick("hold_release");
        checks++;
        if (PC !== RPC || Running !== 1'b1 || InstCount !== 32'd0) begin
            errors++;
            $display("FAIL hold_release: PC=%h Running=%b InstCount=%0d required %h 1 0",
                     PC, Running, InstCount, RPC);
        end
    endtask

    task automatic test_sequential();
        logic [31:0] exp_pc;
        do_reset();
        tick("seq_hold");
        for (int i = 1; i <= 3; i++) begin
            PCSrc = 2'd0;
            tick("seq");
            exp_pc = 32'(4 * i);
            checks++;
            if (PC !== exp_pc || PC4 !== exp_pc + 32'd4) begin
                errors++;
                $display("FAIL seq_pc: PC=%h PC4=%h required %h %h", PC, PC4, exp_pc, exp_pc + 32'd4);
            end
        end
        checks++;
        if (InstCount !== 32'd3) begin
            errors++;
            $display("FAIL seq_count: InstCount=%0d required 3", InstCount);
        end
    endtask

    task automatic test_branch();
        do_reset();
        tick("br_hold");
        tick("br_seq");
        tick("br_seq");
        PCSrc = 2'd1; Zero = 1'b1; imme = 16'hFFFE;
        tick("br_taken");
        checks++;
        if (PC !== 32'd4) begin
            errors++;
            $display("FAIL br_taken: PC=%h required 00000004", PC);
        end
        PCSrc = 2'd0;
        tick("br_seq");
        PCSrc = 2'd1; Zero = 1'b0;
        tick("br_not_taken");
        checks++;
        if (PC !== 32'd12 || InstCount !== 32'd5) begin
            errors++;
            $display("FAIL br_not_taken: PC=%h InstCount=%0d required 0000000c 5", PC, InstCount);
        end
        idle_inputs();
    endtask

    task automatic test_jump();
        do_reset();
        tick("j_hold");
        tick("j_seq");
        PCSrc = 2'd2; addr = 26'h10;
        tick("jump");
        checks++;
        if (PC !== 32'h40 || Running !== 1'b1) begin
            errors++;
            $display("FAIL jump: PC=%h Running=%b required 00000040 1", PC, Running);
        end
        PCSrc = 2'd3; RegData = 32'h0000_0101;
        tick("jr_illegal");
        checks++;
        if (PC !== 32'h40 || {Running, Halted, AddrErr} !== 3'b001 || InstCount !== 32'd3) begin
            errors++;
            $display("FAIL jr_illegal: PC=%h RHE=%b%b%b InstCount=%0d required 00000040 001 3",
                     PC, Running, Halted, AddrErr, InstCount);
        end
        PCSrc = 2'd0;
        tick("err_sticky");
        tick("err_sticky");
        checks++;
        if (PC !== 32'h40 || AddrErr !== 1'b1 || InstCount !== 32'd3) begin
            errors++;
            $display("FAIL err_sticky: PC=%h AddrErr=%b InstCount=%0d required 00000040 1 3",
                     PC, AddrErr, InstCount);
        end
        idle_inputs();
    endtask

    task automatic test_stall_halt();
        do_reset();
        tick("sh_hold");
        repeat (4) tick("sh_seq");
        Stall = 1'b1; Halt = 1'b1; PCSrc = 2'd2; addr = 26'h3;
        tick("stall");
        tick("stall");
        checks++;
        if (PC !== 32'd16 || Running !== 1'b1 || InstCount !== 32'd4) begin
            errors++;
            $display("FAIL stall_hold: PC=%h Running=%b InstCount=%0d required 00000010 1 4",
                     PC, Running, InstCount);
        end
        Stall = 1'b0;
        tick("halt");
        checks++;
        if (PC !== 32'd16 || {Running, Halted, AddrErr} !== 3'b010 || InstCount !== 32'd5) begin
            errors++;
            $display("FAIL halt: PC=%h RHE=%b%b%b InstCount=%0d required 00000010 010 5",
                     PC, Running, Halted, AddrErr, InstCount);
        end
        Halt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            PCSrc = 2'($urandom_range(0, 3));
            tick("halted_sticky");
        end
        checks++;
        if (PC !== 32'd16 || Halted !== 1'b1 || InstCount !== 32'd5) begin
            errors++;
            $display("FAIL halted_sticky: PC=%h Halted=%b InstCount=%0d required 00000010 1 5",
                     PC, Halted, InstCount);
        end
        idle_inputs();
    endtask

    task automatic test_boundary();
        do_reset();
        tick("bd_hold");
        PCSrc = 2'd2; addr = 26'd63;
        tick("jump_last_word");
        checks++;
        if (PC !== 32'd252 || Running !== 1'b1) begin
            errors++;
            $display("FAIL last_word: PC=%h Running=%b required 000000fc 1", PC, Running);
        end
        PCSrc = 2'd0;
        tick("seq_past_end");
        checks++;
        if (PC !== 32'd252 || AddrErr !== 1'b1 || InstCount !== 32'd2) begin
            errors++;
            $display("FAIL past_end: PC=%h AddrErr=%b InstCount=%0d required 000000fc 1 2",
                     PC, AddrErr, InstCount);
        end
        #1;
        Reset = 1'b1;
        model_reset();
        #1;
        checks++;
        if (PC !== RPC || PC4 !== RPC + 32'd4 || InstCount !== 32'd0 ||
            {Running, Halted, AddrErr} !== 3'b000) begin
            errors++;
            $display("FAIL async_reset: PC=%h PC4=%h InstCount=%0d RHE=%b%b%b required %h %h 0 000",
                     PC, PC4, InstCount, Running, Halted, AddrErr, RPC, RPC + 32'd4);
        end
        Reset = 1'b0;
        tick("bd_hold");
        checks++;
        if (PC !== RPC || Running !== 1'b1) begin
            errors++;
            $display("FAIL post_reset: PC=%h Running=%b required %h 1", PC, Running, RPC);
        end
        idle_inputs();
    endtask

    task automatic test_random();
        do_reset();
        tick("rnd_hold");
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) < 2 || (m_state >= 2 && $urandom_range(0, 99) < 30)) begin
                Reset = 1'b1;
                model_reset();
                #1;
                checks++;
                if (PC !== m_pc || InstCount !== m_cnt || {Running, Halted, AddrErr} !== m_flags()) begin
                    errors++;
                    $display("FAIL rnd_reset: PC=%h InstCount=%0d RHE=%b%b%b required %h %0d %b",
                             PC, InstCount, Running, Halted, AddrErr, m_pc, m_cnt, m_flags());
                end
                Reset = 1'b0;
                #1;
            end
            Stall   = ($urandom_range(0, 99) < 20);
            Halt    = ($urandom_range(0, 99) < 4);
            PCSrc   = 2'($urandom_range(0, 3));
            Zero    = 1'($urandom_range(0, 1));
            imme    = 16'($urandom_range(0, 24)) - 16'd12;
            addr    = 26'($urandom_range(0, 70));
            RegData = ($urandom_range(0, 3) == 0) ? $urandom() : 32'(4 * $urandom_range(0, 63));
            tick("rnd");
            checks++;
            if (PC !== m_pc || PC4 !== m_pc + 32'd4 || InstCount !== m_cnt ||
                {Running, Halted, AddrErr} !== m_flags()) begin
                errors++;
                $display("FAIL rnd_step %0d: PC=%h PC4=%h InstCount=%0d RHE=%b%b%b required %h %h %0d %b",
                         i, PC, PC4, InstCount, Running, Halted, AddrErr,
                         m_pc, m_pc + 32'd4, m_cnt, m_flags());
            end
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        model_reset();
        test_reset();
        test_sequential();
        test_branch();
        test_jump();
        test_stall_halt();
        test_boundary();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
